// File: rtl/genius_uc_if.sv
// genius_uc_if: status/control bundle between the Genius control unit and its datapath
//   master: control unit side (reads datapath flags, drives controls and debug/status)
//   slave:  datapath side (drives flags, reads controls)
interface genius_uc_if;
  logic iniciar;
  logic botoesIgualMemoria;
  logic fimL;
  logic fimM;
  logic meioM;
  logic endecoIgualLimite;
  logic jogada_feita;
  logic timeout;
  logic zeraE;
  logic contaE;
  logic zeraL;
  logic contaL;
  logic zeraR;
  logic zeraM;
  logic contaM;
  logic registraR;
  logic selecionaMemoria;
  logic reset_random;
  logic contaT;
  logic [1:0] seletor;
  logic pronto;
  logic ganhou;
  logic perdeu;
  logic db_timeout;
  logic [4:0] db_estado;
  modport master (
    input  iniciar, botoesIgualMemoria, fimL, fimM, meioM, endecoIgualLimite, jogada_feita, timeout,
    output zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, selecionaMemoria,
           reset_random, contaT, seletor, pronto, ganhou, perdeu, db_timeout, db_estado
  );
  modport slave (
    output iniciar, botoesIgualMemoria, fimL, fimM, meioM, endecoIgualLimite, jogada_feita, timeout,
    input  zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, selecionaMemoria,
           reset_random, contaT, seletor, pronto, ganhou, perdeu, db_timeout, db_estado
  );
endinterface

// File: rtl/genius_uc.sv
// genius_uc: Moore control unit sequencing the Genius (Simon) game datapath
//   clock, reset : rising-edge clock, synchronous active-high reset to inicial
//   bus (master) : datapath status flags in; datapath controls, game status and db_estado out
module genius_uc (
  input logic clock,
  input logic reset,
  genius_uc_if.master bus
);
  typedef enum logic [4:0] {
    inicial        = 5'h00,
    preparacao     = 5'h01,
    inicio_rodada  = 5'h02,
    mostra_led     = 5'h03,
    apaga_led      = 5'h04,
    verifica_led   = 5'h05,
    proximo_led    = 5'h06,
    inicio_jogada  = 5'h07,
    espera_jogada  = 5'h08,
    registra       = 5'h09,
    comparacao     = 5'h0A,
    proxima_jogada = 5'h0B,
    fim_rodada     = 5'h0C,
    proxima_rodada = 5'h0D,
    fim_acertou    = 5'h0E,
    fim_errou      = 5'h0F,
    fim_timeout    = 5'h10
  } state_t;
  state_t state, next;
  always_ff @(posedge clock)
    state <= reset ? inicial : next;
  // Unlisted codes 11..1F fall through to inicial.
  always_comb begin
    next = inicial;
    case (state)
      inicial:        next = bus.iniciar ? preparacao : inicial;
      preparacao:     next = inicio_rodada;
      inicio_rodada:  next = mostra_led;
      mostra_led:     next = bus.meioM ? apaga_led : mostra_led;
      apaga_led:      next = bus.fimM ? verifica_led : apaga_led;
      verifica_led:   next = bus.endecoIgualLimite ? inicio_jogada : proximo_led;
      proximo_led:    next = mostra_led;
      inicio_jogada:  next = espera_jogada;
      espera_jogada:  next = bus.jogada_feita ? registra : bus.timeout ? fim_timeout : espera_jogada;
      registra:       next = comparacao;
      comparacao:     next = !bus.botoesIgualMemoria ? fim_errou :
                             bus.endecoIgualLimite ? fim_rodada : proxima_jogada;
      proxima_jogada: next = espera_jogada;
      fim_rodada:     next = bus.fimL ? fim_acertou : proxima_rodada;
      proxima_rodada: next = inicio_rodada;
      fim_acertou:    next = bus.iniciar ? preparacao : fim_acertou;
      fim_errou:      next = bus.iniciar ? preparacao : fim_errou;
      fim_timeout:    next = bus.iniciar ? preparacao : fim_timeout;
      default:        next = inicial;
    endcase
  end
  assign bus.zeraE            = state inside {preparacao, inicio_rodada, inicio_jogada};
  assign bus.contaE           = state inside {proximo_led, proxima_jogada};
  assign bus.zeraL            = state == preparacao;
  assign bus.contaL           = state == proxima_rodada;
  assign bus.zeraR            = state inside {preparacao, inicio_jogada};
  assign bus.zeraM            = state inside {preparacao, inicio_rodada, verifica_led};
  assign bus.contaM           = state inside {mostra_led, apaga_led};
  assign bus.registraR        = state == registra;
  assign bus.selecionaMemoria = state == preparacao;
  assign bus.reset_random     = state == inicial;
  // Leaving espera_jogada drops contaT, which clears the timeout counter.
  assign bus.contaT           = state == espera_jogada;
  assign bus.seletor          = state == mostra_led ? 2'b01 :
                                state inside {espera_jogada, registra} ? 2'b10 : 2'b00;
  assign bus.pronto           = state inside {fim_acertou, fim_errou, fim_timeout};
  assign bus.ganhou           = state == fim_acertou;
  assign bus.perdeu           = state inside {fim_errou, fim_timeout};
  assign bus.db_timeout       = state == fim_timeout;
  assign bus.db_estado        = state;
endmodule

// File: tb/tb_genius_uc.sv
// tb_genius_uc: scoreboard bench for genius_uc with a small behavioural datapath model
module tb_genius_uc;
  logic clock, reset;
  genius_uc_if bus();
  genius_uc dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int compared = 0;
  int mismatched = 0;
  logic [4:0] exp_q[$];
  logic [7:0] e, l, m, t;
  logic ok;
  int cnt_ed = 0, cnt_ep = 0, cnt_l = 0;
  // Datapath model: shortened display (meio at 2, fim at 5) and timeout (9) counts.
  always @(posedge clock) begin
    e <= bus.zeraE ? 8'd0 : bus.contaE ? e + 8'd1 : e;
    l <= bus.zeraL ? 8'd0 : bus.contaL ? l + 8'd1 : l;
    m <= bus.zeraM ? 8'd0 : bus.contaM ? m + 8'd1 : m;
    t <= bus.contaT ? t + 8'd1 : 8'd0;
    if (bus.contaE && bus.db_estado == 5'h06) cnt_ed <= cnt_ed + 1;
    if (bus.contaE && bus.db_estado == 5'h0B) cnt_ep <= cnt_ep + 1;
    if (bus.contaL) cnt_l <= cnt_l + 1;
  end
  assign bus.endecoIgualLimite  = e == l;
  assign bus.fimL               = l == 8'd15;
  assign bus.meioM              = m == 8'd2;
  assign bus.fimM               = m == 8'd5;
  assign bus.timeout            = t == 8'd9;
  assign bus.botoesIgualMemoria = ok;
  logic [16:0] obs_v;
  assign obs_v = {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR, bus.zeraM, bus.contaM,
                  bus.registraR, bus.selecionaMemoria, bus.reset_random, bus.contaT, bus.seletor,
                  bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};
  function automatic logic [16:0] dec(input logic [4:0] s);
    logic ze, ce, zl, cl, zr, zm, cm, rr, sm, rnd, ct, pr, ga, pe, dt;
    logic [1:0] sel;
    {ze, ce, zl, cl, zr, zm, cm, rr, sm, rnd, ct, pr, ga, pe, dt} = '0;
    sel = 2'b00;
    case (s)
      5'h00: rnd = 1'b1;
      5'h01: begin ze = 1'b1; zl = 1'b1; zr = 1'b1; zm = 1'b1; sm = 1'b1; end
      5'h02: begin ze = 1'b1; zm = 1'b1; end
      5'h03: begin sel = 2'b01; cm = 1'b1; end
      5'h04: cm = 1'b1;
      5'h05: zm = 1'b1;
      5'h06: ce = 1'b1;
      5'h07: begin ze = 1'b1; zr = 1'b1; end
      5'h08: begin sel = 2'b10; ct = 1'b1; end
      5'h09: begin sel = 2'b10; rr = 1'b1; end
      5'h0B: ce = 1'b1;
      5'h0D: cl = 1'b1;
      5'h0E: begin pr = 1'b1; ga = 1'b1; end
      5'h0F: begin pr = 1'b1; pe = 1'b1; end
      5'h10: begin pr = 1'b1; pe = 1'b1; dt = 1'b1; end
      default: ;
    endcase
    return {ze, ce, zl, cl, zr, zm, cm, rr, sm, rnd, ct, sel, pr, ga, pe, dt};
  endfunction
  task automatic step(input logic [4:0] s);
    logic [4:0] x;
    exp_q.push_back(s);
    @(posedge clock); #1;
    x = exp_q.pop_front();
    compared++;
    assert ({obs_v, bus.db_estado} === {dec(x), x}) else begin
      mismatched++;
      $error("FAIL step: observed state %h outs %b, expected state %h outs %b", bus.db_estado, obs_v, x, dec(x));
    end
  endtask
  task automatic wait_state(input logic [4:0] s, input int budget);
    int n = 0;
    while (bus.db_estado !== s && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    compared++;
    assert (bus.db_estado === s) else begin
      mismatched++;
      $error("FAIL wait_state: observed %h expected %h after %0d cycles", bus.db_estado, s, n);
    end
  endtask
  task automatic check_int(input string tag, input int obs, input int expv);
    compared++;
    assert (obs == expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic press(input logic good);
    ok = good;
    bus.jogada_feita = 1'b1;
    step(5'h09);
    bus.jogada_feita = 1'b0;
    step(5'h0A);
  endtask
  int l0, ed0, ep0;
  initial begin
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.jogada_feita = 1'b0;
    ok = 1'b1;
    step(5'h00);
    step(5'h00);
    reset = 1'b0;
    step(5'h00);
    bus.iniciar = 1'b1;
    step(5'h01);
    bus.iniciar = 1'b0;
    step(5'h02);
    step(5'h03);
    bus.jogada_feita = 1'b1;
    step(5'h03);
    bus.jogada_feita = 1'b0;
    wait_state(5'h08, 200);
    l0 = cnt_l;
    press(1'b1);
    step(5'h0C);
    step(5'h0D);
    step(5'h02);
    check_int("contaL_round0", cnt_l - l0, 1);
    wait_state(5'h08, 200);
    press(1'b1);
    step(5'h0B);
    step(5'h08);
    press(1'b0);
    step(5'h0F);
    step(5'h0F);
    step(5'h0F);
    bus.iniciar = 1'b1;
    step(5'h01);
    bus.iniciar = 1'b0;
    step(5'h02);
    wait_state(5'h08, 200);
    for (int i = 0; i < 9; i++) step(5'h08);
    step(5'h10);
    step(5'h10);
    bus.iniciar = 1'b1;
    step(5'h01);
    step(5'h02);
    bus.iniciar = 1'b0;
    l0 = cnt_l; ed0 = cnt_ed; ep0 = cnt_ep;
    for (int r = 0; r < 16; r++)
      for (int p = 0; p <= r; p++) begin
        wait_state(5'h08, 200);
        if (r == 0) begin
          for (int i = 0; i < 9; i++) step(5'h08);
        end
        press(1'b1);
      end
    wait_state(5'h0E, 20);
    step(5'h0E);
    check_int("contaL_game", cnt_l - l0, 15);
    check_int("contaE_display", cnt_ed - ed0, 120);
    check_int("contaE_play", cnt_ep - ep0, 120);
    bus.iniciar = 1'b1;
    step(5'h01);
    bus.iniciar = 1'b0;
    wait_state(5'h03, 20);
    reset = 1'b1;
    step(5'h00);
    reset = 1'b0;
    step(5'h00);
    bus.iniciar = 1'b1;
    step(5'h01);
    bus.iniciar = 1'b0;
    wait_state(5'h08, 200);
    reset = 1'b1;
    step(5'h00);
    reset = 1'b0;
    step(5'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/genius_uc.md
Name: genius_uc

Overview:
- Moore control unit that sequences the Genius (Simon) game datapath: ROM sequence display, player entry, limit/round counters, display timing and timeout counters.
- Sits beside fluxo_dados in the genius top level. It consumes the datapath status flags and drives every datapath control input.
- Game flow: each round shows sequence positions 0..limite; the player repeats them; limite grows by one per round until fimL.

Parameters:
- None. All timing comes from the fluxo_dados counters: display M=1000, timeout M=5000.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; forces state inicial
- iniciar  in  1  start/restart request, level-sampled
- botoesIgualMemoria  in  1  registered play equals memory word
- fimL  in  1  limit counter at final round
- fimM  in  1  display counter terminal count
- meioM  in  1  display counter half count
- endecoIgualLimite  in  1  address equals limit
- jogada_feita  in  1  one-cycle button edge pulse
- timeout  in  1  timeout counter terminal count
- zeraE, contaE, zeraL, contaL, zeraR, zeraM, contaM, registraR, selecionaMemoria, reset_random, contaT  out  1 each  datapath controls
- seletor  out  2  LED mux select: 00 off, 01 memory, 10 buttons
- pronto  out  1  game finished
- ganhou  out  1  player won
- perdeu  out  1  player lost (error or timeout)
- db_timeout  out  1  loss was caused by timeout
- db_estado  out  5  current state code

Behaviour:
- State register is 5 bits and updates on the rising clock edge.
- Outputs are pure decodes of the state (Moore). There is no combinational path from inputs to outputs.
- An output not listed for a state is 0; seletor defaults to 00.
- reset=1 at an edge forces inicial from any state, including mid-display and mid-play.
- After reset: reset_random=1 and all other outputs are 0.

States (code: outputs; transitions):
- 00 inicial: reset_random. iniciar -> preparacao.
- 01 preparacao: zeraE, zeraL, zeraR, zeraM, selecionaMemoria (the random block latches the memory choice). -> inicio_rodada.
- 02 inicio_rodada: zeraE, zeraM. -> mostra_led.
- 03 mostra_led: seletor=01, contaM. meioM -> apaga_led.
- 04 apaga_led: seletor=00, contaM. fimM -> verifica_led.
- 05 verifica_led: zeraM. endecoIgualLimite -> inicio_jogada; else -> proximo_led.
- 06 proximo_led: contaE. -> mostra_led.
- 07 inicio_jogada: zeraE, zeraR. -> espera_jogada.
- 08 espera_jogada: seletor=10, contaT.
  - jogada_feita -> registra.
  - else timeout -> fim_timeout.
  - If both are high in the same cycle, jogada_feita wins.
- 09 registra: registraR, seletor=10. -> comparacao. contaT drops here, which clears the timeout counter.
- 0A comparacao:
  - !botoesIgualMemoria -> fim_errou.
  - else endecoIgualLimite -> fim_rodada.
  - else -> proxima_jogada.
- 0B proxima_jogada: contaE. -> espera_jogada.
- 0C fim_rodada: fimL -> fim_acertou; else -> proxima_rodada.
- 0D proxima_rodada: contaL. -> inicio_rodada.
- 0E fim_acertou: pronto, ganhou. iniciar -> preparacao.
- 0F fim_errou: pronto, perdeu. iniciar -> preparacao.
- 10 fim_timeout: pronto, perdeu, db_timeout. iniciar -> preparacao.
- Codes 11..1F are illegal and go to inicial on the next edge.

Timing and boundary rules:
- Each sequence item takes meioM-reach cycles lit, then fimM-reach cycles dark, then 2 overhead cycles (verifica_led, proximo_led).
- Play latency: jogada_feita pulse -> registra next edge -> compare one cycle later. The sync ROM output is stable because the address is held from inicio_jogada or proxima_jogada.
- Round 0 has limite=0: exactly one item is shown and one play is required.
- A win requires a correct final play with fimL=1 (limite=15).
- iniciar held high in a final state restarts a new game immediately, with no wait for release.
- Extra jogada_feita pulses during mostra_led or apaga_led are ignored.

Test Plan:
- reset for 1 cycle, then iniciar pulse -> db_estado 00->01->02->03; zeraL=1 only in 01; seletor=01 in 03.
- Round 0 with memory[0]=0001: press 0001 -> states 08,09,0A,0C,0D,02; contaL pulses exactly 1 cycle.
- Round 1 with a wrong second play (0100 vs 0010) -> state 0F; pronto=1, perdeu=1, ganhou=0; state holds until iniciar.
- No press in espera_jogada until timeout -> state 10; db_timeout=1, perdeu=1; contaT was high for all 08 cycles.
- Full correct game for 16 rounds -> state 0E, ganhou=1. Count contaE and contaL pulses: contaL=15 (no pulse in the winning round); contaE=120 in display plus 120 in play.
- reset asserted during mostra_led and during espera_jogada -> inicial at the next edge; all outputs are the inicial decode (reset_random=1, others 0).
